// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the parameterised FIFO slice.
//   ptr_w()          : pointer width for a given depth (index bits + wrap bit)
//   DEF_AFULL_MARGIN : default almost_full threshold sits this far below DEPTH
//   DEF_AEMPTY_TH    : default almost_empty threshold
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam int DEF_AFULL_MARGIN = 2;
   localparam int DEF_AEMPTY_TH    = 1;

   // Index bits address storage; the extra MSB distinguishes full from empty.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_ptr.sv
// -----------------------------------------------------------------------------
// fifo_ptr
// Wrap-bit pointer register. Counts modulo 2^PW with no special case at
// wrap-around; the MSB toggles each time the index bits roll over.
// Ports:
//   clk  : rising-edge clock
//   clr  : synchronous clear (priority over inc)
//   inc  : increment enable
//   q    : pointer value, PW bits
// -----------------------------------------------------------------------------
module fifo_ptr #(
   parameter int PW = 4
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          inc,
   output logic [PW-1:0] q
);

   logic [PW-1:0] r_ptr;

   // Pointer state: clear wins, otherwise advance when enabled.
   always_ff @(posedge clk) begin
      if (clr) begin
         r_ptr <= {PW{1'b0}};
      end else if (inc) begin
         r_ptr <= r_ptr + {{(PW-1){1'b0}}, 1'b1};
      end else begin
         r_ptr <= r_ptr;
      end
   end

   assign q = r_ptr;

endmodule

// File: rtl/param_fifo.sv
// -----------------------------------------------------------------------------
// param_fifo
// Synchronous show-ahead FIFO with occupancy count, threshold flags and
// optional sticky error flags.
//
// Optional feature macro: FIFO_ERR_EN
//   defined   : overflow/underflow are sticky registers set by a rejected
//               push/pop and cleared only by rst
//   undefined : overflow/underflow are tied low, no flag registers exist
//
// Parameters: WIDTH (data bits), DEPTH (power of two, >=2),
//             AFULL_TH (1..DEPTH-1), AEMPTY_TH (0..DEPTH-1)
// Ports:
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   push, data_in     : write request and data
//   pop               : read request
//   data_out          : head entry, valid combinationally while !empty
//   full, empty       : occupancy extremes
//   almost_full/empty : count >= AFULL_TH / count <= AEMPTY_TH
//   count             : occupancy 0..DEPTH
//   overflow/underflow: sticky error flags (see FIFO_ERR_EN)
// -----------------------------------------------------------------------------
module param_fifo
   import fifo_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 8,
   parameter int AFULL_TH  = DEPTH - DEF_AFULL_MARGIN,
   parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             data_in,
   output logic [WIDTH-1:0]             data_out,
   output logic                         full,
   output logic                         empty,
   output logic                         almost_full,
   output logic                         almost_empty,
   output logic [$clog2(DEPTH):0]       count,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int PW = ptr_w(DEPTH);
   localparam int AW = PW - 1;
   localparam logic [PW-1:0] LP_AFULL  = PW'(AFULL_TH);
   localparam logic [PW-1:0] LP_AEMPTY = PW'(AEMPTY_TH);

   logic [WIDTH-1:0] r_mem [DEPTH];

   logic [PW-1:0] w_wr_ptr;
   logic [PW-1:0] w_rd_ptr;
   logic [PW-1:0] w_count;
   logic          w_full;
   logic          w_empty;
   logic          w_push_acc;
   logic          w_pop_acc;
   logic          w_wr_inc;
   logic          w_rd_inc;

   // Status decode from registered pointers only.
   always_comb begin
      w_empty = (w_wr_ptr == w_rd_ptr);
      w_full  = (w_wr_ptr[AW-1:0] == w_rd_ptr[AW-1:0]) &&
                (w_wr_ptr[AW] != w_rd_ptr[AW]);
      w_count = w_wr_ptr - w_rd_ptr;
   end

   // Handshake acceptance. A full FIFO still takes a push when the head is
   // leaving in the same cycle; an empty FIFO never takes a pop, even if a
   // push would make data available by the next edge.
   always_comb begin
      w_pop_acc  = pop && !w_empty;
      w_push_acc = push && (!w_full || pop);
      w_wr_inc   = w_push_acc && !rst;
      w_rd_inc   = w_pop_acc && !rst;
   end

   fifo_ptr #(.PW(PW)) u_wr_ptr (
      .clk (clk),
      .clr (rst),
      .inc (w_wr_inc),
      .q   (w_wr_ptr)
   );

   fifo_ptr #(.PW(PW)) u_rd_ptr (
      .clk (clk),
      .clr (rst),
      .inc (w_rd_inc),
      .q   (w_rd_ptr)
   );

   // Storage write; deliberately unreset, contents are discarded logically
   // by clearing the pointers.
   always_ff @(posedge clk) begin
      if (w_wr_inc) begin
         r_mem[w_wr_ptr[AW-1:0]] <= data_in;
      end
   end

   // Show-ahead read. When full with push+pop, the write targets this same
   // slot, but only lands at the edge, so the current head is unaffected.
   assign data_out     = r_mem[w_rd_ptr[AW-1:0]];
   assign full         = w_full;
   assign empty        = w_empty;
   assign count        = w_count;
   assign almost_full  = (w_count >= LP_AFULL);
   assign almost_empty = (w_count <= LP_AEMPTY);

`ifdef FIFO_ERR_EN
   logic r_overflow;
   logic r_underflow;

   // Sticky error flags, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (push && !w_push_acc) begin
            r_overflow <= 1'b1;
         end
         if (pop && !w_pop_acc) begin
            r_underflow <= 1'b1;
         end
      end
   end

   assign overflow  = r_overflow;
   assign underflow = r_underflow;
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_param_fifo.sv
module tb_param_fifo;

   localparam int W = 8;
   localparam int D = 8;

`ifdef FIFO_ERR_EN
   localparam logic ERR = 1'b1;
`else
   localparam logic ERR = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         push = 1'b0;
   logic         pop = 1'b0;
   logic [W-1:0] data_in = 8'h00;
   logic [W-1:0] data_out;
   logic         full, empty, almost_full, almost_empty;
   logic [3:0]   count;
   logic         overflow, underflow;

   int n_cmp  = 0;
   int n_fail = 0;

   param_fifo #(.WIDTH(W), .DEPTH(D), .AFULL_TH(6), .AEMPTY_TH(1)) dut (
      .clk          (clk),
      .rst          (rst),
      .push         (push),
      .pop          (pop),
      .data_in      (data_in),
      .data_out     (data_out),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       push;
      logic       pop;
      logic [7:0] din;
      logic [3:0] cnt;
      logic       emp;
      logic       ful;
      logic       af;
      logic       ae;
      logic       chk_dout;
      logic [7:0] dout;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic p, input logic q, input logic [7:0] d);
      push = p; pop = q; data_in = d;
      @(posedge clk); #1;
      push = 1'b0; pop = 1'b0;
   endtask

   task automatic chk_status(input string name, input logic [3:0] c, input logic e, input logic f);
      chk({name, ".count"}, 32'(count), 32'(c));
      chk({name, ".empty"}, 32'(empty), 32'(e));
      chk({name, ".full"},  32'(full),  32'(f));
   endtask

   initial begin
      // Vector table: 8 pushes of 0x10..0x17, then 8 pops.
      for (int i = 0; i < 8; i++) begin
         vecs[i] = '{1'b1, 1'b0, 8'(8'h10 + i), 4'(i + 1), 1'b0, (i == 7),
                     (i + 1 >= 6), (i + 1 <= 1), 1'b1, 8'h10};
      end
      for (int k = 0; k < 8; k++) begin
         vecs[8 + k] = '{1'b0, 1'b1, 8'h00, 4'(7 - k), (k == 7), 1'b0,
                         (7 - k >= 6), (7 - k <= 1), (k < 7), 8'(8'h11 + k)};
      end

      // Reset state.
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk_status("reset", 4'd0, 1'b1, 1'b0);
      chk("reset.af", 32'(almost_full), 32'd0);
      chk("reset.ae", 32'(almost_empty), 32'd1);
      chk("reset.ovf", 32'(overflow), 32'd0);
      chk("reset.unf", 32'(underflow), 32'd0);

      // Fill and drain from the table.
      for (int v = 0; v < 16; v++) begin
         step(vecs[v].push, vecs[v].pop, vecs[v].din);
         chk($sformatf("vec%0d", v), 32'(count), 32'(vecs[v].cnt));
         chk($sformatf("vec%0d.empty", v), 32'(empty), 32'(vecs[v].emp));
         chk($sformatf("vec%0d.full", v), 32'(full), 32'(vecs[v].ful));
         chk($sformatf("vec%0d.af", v), 32'(almost_full), 32'(vecs[v].af));
         chk($sformatf("vec%0d.ae", v), 32'(almost_empty), 32'(vecs[v].ae));
         if (vecs[v].chk_dout) begin
            chk($sformatf("vec%0d.dout", v), 32'(data_out), 32'(vecs[v].dout));
         end
      end

      // Push on full alone, then push+pop on full.
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
      step(1'b1, 1'b0, 8'hAA);
      chk_status("ovf_push", 4'd8, 1'b0, 1'b1);
      chk("ovf_push.ovf", 32'(overflow), 32'(ERR));
      chk("ovf_push.head", 32'(data_out), 32'h20);
      push = 1'b1; pop = 1'b1; data_in = 8'hBB;
      #1 chk("fullpp.pre_dout", 32'(data_out), 32'h20);
      @(posedge clk); #1;
      push = 1'b0; pop = 1'b0;
      chk_status("fullpp", 4'd8, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("drain%0d", i), 32'(data_out),
             (i < 7) ? 32'(8'h21 + i) : 32'hBB);
         step(1'b0, 1'b1, 8'h00);
      end
      chk_status("drained", 4'd0, 1'b1, 1'b0);

      // Push+pop on empty: pop ignored.
      step(1'b1, 1'b1, 8'h55);
      chk_status("emptypp", 4'd1, 1'b0, 1'b0);
      chk("emptypp.dout", 32'(data_out), 32'h55);
      chk("emptypp.unf", 32'(underflow), 32'(ERR));
      step(1'b0, 1'b1, 8'h00);

      // Wrap-around with push-then-pop pairs.
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0, 8'(i));
         chk($sformatf("wrap%0d.cnt", i), 32'(count), 32'd1);
         chk($sformatf("wrap%0d.dout", i), 32'(data_out), 32'(i));
         step(1'b0, 1'b1, 8'h00);
         chk($sformatf("wrap%0d.empty", i), 32'(empty), 32'd1);
      end

      // Reset mid-operation with push asserted.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h30 + i));
      chk("pre_rst.cnt", 32'(count), 32'd5);
      rst = 1'b1;
      step(1'b1, 1'b0, 8'hEE);
      rst = 1'b0;
      chk_status("midrst", 4'd0, 1'b1, 1'b0);
      chk("midrst.ovf", 32'(overflow), 32'd0);
      chk("midrst.unf", 32'(underflow), 32'd0);

      // Pop on empty: pointers untouched, next push lands at the head.
      step(1'b0, 1'b1, 8'h00);
      chk_status("popempty", 4'd0, 1'b1, 1'b0);
      chk("popempty.unf", 32'(underflow), 32'(ERR));
      step(1'b1, 1'b0, 8'h66);
      chk_status("after_pe", 4'd1, 1'b0, 1'b0);
      chk("after_pe.dout", 32'(data_out), 32'h66);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 8, entry count (power of two, >=2).
REQ-003 The block SHALL have parameter AFULL_TH, default DEPTH-2, almost_full threshold (1..DEPTH-1).
REQ-004 The block SHALL have parameter AEMPTY_TH, default 1, almost_empty threshold (0..DEPTH-1).
REQ-005 The block SHALL have port clk, input, 1 bit, sole clock, rising-edge.
REQ-006 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-007 The block SHALL have port push, input, 1 bit, write request.
REQ-008 The block SHALL have port pop, input, 1 bit, read request.
REQ-009 The block SHALL have port data_in, input, WIDTH bits, write data.
REQ-010 The block SHALL have port data_out, output, WIDTH bits, head entry (show-ahead).
REQ-011 The block SHALL have ports full, empty, almost_full and almost_empty, each output, 1 bit, status flags.
REQ-012 The block SHALL have port count, output, $clog2(DEPTH)+1 bits, current occupancy.
REQ-013 The block SHALL have ports overflow and underflow, each output, 1 bit, sticky error flags.

Function
REQ-014 Read and write pointers SHALL each be $clog2(DEPTH)+1 bits: the low bits index storage, the MSB is a wrap bit.
REQ-015 empty SHALL be 1 when the pointers are equal; full SHALL be 1 when the index bits are equal and the wrap bits differ.
REQ-016 count SHALL equal wrPtr-rdPtr modulo 2^($clog2(DEPTH)+1), giving a range of 0..DEPTH.
REQ-017 almost_full SHALL be count>=AFULL_TH; almost_empty SHALL be count<=AEMPTY_TH; all flags SHALL be combinational from registered state.
REQ-018 An accepted push SHALL write data_in to entry wrPtr at the clock edge and increment wrPtr; push SHALL be accepted when !full, or when full with pop asserted in the same cycle.
REQ-019 An accepted pop SHALL increment rdPtr; pop SHALL be accepted when !empty; a pop on empty SHALL be ignored even if push is asserted in the same cycle.
REQ-020 data_out SHALL be entry rdPtr combinationally, with zero read latency; its value while empty is don't-care.
REQ-021 Simultaneous accepted push and pop SHALL leave count unchanged and SHALL NOT corrupt data_out of the current cycle.
REQ-022 A rejected push SHALL NOT change storage or pointers; a rejected pop SHALL NOT change pointers.
REQ-023 Pointers SHALL wrap naturally modulo 2^($clog2(DEPTH)+1), with no special case at wrap-around.

Reset
REQ-024 While rst=1 at a clock edge, pointers and error flags SHALL clear; rst SHALL take priority over push and pop.
REQ-025 After reset: empty=1, full=0, count=0, almost_full=0, almost_empty=1, overflow=0, underflow=0.
REQ-026 Storage SHALL NOT be reset; a reset mid-operation SHALL discard all contents logically.

Configuration
REQ-027 With FIFO_ERR_EN defined, overflow SHALL set on a rejected push and underflow SHALL set on a rejected pop, each holding until rst.
REQ-028 With FIFO_ERR_EN undefined, overflow and underflow SHALL be tied to 0 and no flag registers SHALL exist.

Structure
REQ-029 Package fifo_pkg SHALL hold the pointer-width function (clog2+1) and the default-threshold constants.
REQ-030 Sub-module fifo_ptr (wrap-bit pointer register with synchronous clear and increment enable) SHALL be instantiated once for each pointer.
REQ-031 Storage SHALL be an unreset register array written on accepted push only.

Verification (WIDTH=8, DEPTH=8, AFULL_TH=6, AEMPTY_TH=1)
REQ-032 Bench: push 0x10..0x17 -> full=1 and count=8 after the 8th push; almost_full rises after the 6th push; pop 8 times -> data_out 0x10..0x17 in order, then empty=1.
REQ-033 Bench: full, then push 0xAA alone -> rejected, count=8, overflow=1 (FIFO_ERR_EN); then push 0xBB with pop -> count=8, 0xBB read last.
REQ-034 Bench: empty, then push 0x55 with pop -> pop ignored, count=1, data_out=0x55, underflow=1 (FIFO_ERR_EN).
REQ-035 Bench: 20 push-then-pop pairs of value i -> wrap bits toggle, data_out=i each pop, empty throughout the gaps.
REQ-036 Bench: count=5, then rst with push=1 -> count=0, empty=1, all error flags 0 on the next cycle.
REQ-037 Bench: FIFO_ERR_EN undefined, pop while empty -> underflow stays 0 and pointers are unchanged.
